prog_counter: RTL
=================

# prog_counter

Parametrised programmable counter; the next generation of the single-mode demo counter in our Tiny Tapeout designs. It adds configurable width, a programmable limit, up/down direction, wrap/saturate/one-shot modes, a compare output and an optional clock prescaler. It sits behind the `tt_um_*` top wrapper, which maps its ports to `ui_in`/`uio_*`/`uo_out` and inverts `rst_n` into `rst`.

## Interface
- `WIDTH`, 8, counter width in bits (≥2)
- `PRESCALE_W`, 8, prescaler width in bits; used only when the prescaler is compiled in
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `en`  in  1  count enable
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value loaded on `load`
- `up`  in  1  1 = count up, 0 = count down
- `mode`  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- `limit`  in  WIDTH  upper bound; counting range is 0..limit
- `cmp_val`  in  WIDTH  compare value
- `prescale`  in  PRESCALE_W  step divider; present only with `PROG_COUNTER_PRESCALE_EN`
- `count`  out  WIDTH  current count
- `tick`  out  1  one-cycle boundary-event pulse
- `match`  out  1  high while `count == cmp_val`
- `done`  out  1  one-shot finished; sticky

## Operation
- Reset values: `count`=0, `tick`=0, `match`=0 (even if `cmp_val`=0), `done`=0, prescaler counter=0.
- Priority per edge: `rst` > `load` > step > hold.
- `load`: `count`←`load_val`, `done`←0, `tick`←0, prescaler counter←0; `en` is ignored that cycle.
- The step strobe is `en` (or the prescaler output when the prescaler is compiled in). With no step, `count` holds and `tick`=0.
- Up step, wrap mode:
  - if `count` ≥ `limit`: `count`←0 and `tick`=1;
  - otherwise `count`+1.
- Down step, wrap mode:
  - if `count`=0: `count`←`limit` and `tick`=1;
  - otherwise `count`−1.
- Saturate mode:
  - Up step: `count`←min(`count`+1, `limit`). If `count` ≥ `limit` before the step, `count`←`limit`.
  - Down step: `count`←`count`−1, floored at 0.
  - `tick`=1 only on the step that lands on the boundary (`limit` up, 0 down) from a non-boundary value. Steps at the boundary hold with `tick`=0.
- One-shot mode:
  - Behaves as saturate.
  - The landing step sets `done`=1 together with `tick`.
  - While `done`=1, steps are ignored.
  - `done` clears only on `load` or `rst`. Changing `mode` does not clear `done`, but `done` gates steps only in one-shot mode.
- `count` > `limit`, reachable via `load` or by lowering `limit`:
  - up in wrap → 0 with `tick`;
  - up in saturate/one-shot → `limit` with `tick`;
  - down decrements normally.
- `limit`=0:
  - wrap mode: every step yields `count`=0 and `tick`=1;
  - saturate mode: the first step from a nonzero value lands on 0 with `tick`, then holds.
- All arithmetic is modulo 2^WIDTH; no intermediate value exceeds WIDTH+1 bits.

## Timing
- Single clock domain. Every output is a flop; there are no combinational input-to-output paths.
- `count`, `tick` and `done` update on the edge that samples the step. `tick` is high in the same cycle the new `count` is visible.
- `match` is registered from the next-state value, so it aligns with `count`. A change on `cmp_val` alone is reflected after the next edge.
- `rst` asserts asynchronously, immediately and without a clock edge. Deassertion is synchronised by the wrapper.
- Throughput: one step per cycle maximum.

## Configuration
- `PROG_COUNTER_PRESCALE_EN` defined:
  - A prescaler counter runs 0..`prescale` while `en`=1 and holds while `en`=0.
  - The step strobe fires on the cycle it equals `prescale`; the prescaler counter then returns to 0.
  - `prescale`=0 gives a step every `en` cycle.
  - Changing `prescale` below the current prescaler value forces a step and a return to 0 on the next `en` cycle.
- Undefined: the `prescale` port and the prescaler logic are absent, and step = `en`.

## Structure
- `prog_counter_pkg`: `counter_mode_e` enum (`MODE_WRAP`, `MODE_SAT`, `MODE_ONESHOT`, `MODE_RSVD`) and default width constants.
- One sub-module, `prog_counter_prescaler`, instantiated only under `PROG_COUNTER_PRESCALE_EN`.

## Test plan
- Wrap up: WIDTH=8, `limit`=5, `en`=1 held, `up`=1 → `count` 0,1,2,3,4,5,0,1; `tick`=1 only in the cycle showing the 5→0 wrap.
- Saturate down: load 3, `up`=0, `mode`=01 → `count` 3,2,1,0,0,0; `tick` once, coincident with 0.
- One-shot with compare: `limit`=3, `cmp_val`=2 → `match` high exactly while `count`=2; `done`=1 at `count`=3 and held for 10 further `en` cycles; `load` with `load_val`=0 → `count`=0, `done`=0.
- Load priority and out-of-range: `load`=1, `en`=1, `load_val`=200, `limit`=10, wrap mode → `count`=200; next step → 0 with `tick`.
- Prescaler (macro defined): `prescale`=2, `en`=1 → `count` increments every 3rd cycle; drop `en` for 2 cycles → phase preserved.
- Async reset: `rst` pulsed mid-count (`count`=4, `done`=1) between clock edges → `count`=0, `done`=0, `match`=0 immediately; counting resumes from 0 after release.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types and default sizing for the programmable counter and its prescaler.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } counter_mode_e;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 8;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Step divider: emits one step strobe every (prescale+1) enabled cycles.
module prog_counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step
);

  logic [PRESCALE_W-1:0] r_div;
  logic                  w_wrap;

  // ">=" rather than "==" so lowering prescale below r_div still returns to 0.
  assign w_wrap = (r_div >= prescale);
  assign step   = en && !clr && w_wrap;

  // NOTE: async reset goes in the sensitivity list and is tested first; state
  // registers use non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (clr) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap/saturate/one-shot modes and compare.
// Define PROG_COUNTER_PRESCALE_EN to add the prescale port and step divider.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [WIDTH-1:0]      cmp_val,
`ifdef PROG_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  match,
  output logic                  done
);

  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_match;
  logic             r_done;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tick_nxt;
  logic             w_done_nxt;
  logic             w_step;
  logic             w_sat;
  logic             w_frozen;
  counter_mode_e    w_mode;

`ifdef PROG_COUNTER_PRESCALE_EN
  prog_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .step     (w_step)
  );
`else
  assign w_step = en;
`endif

  assign w_mode   = counter_mode_e'(mode);
  assign w_sat    = (w_mode == MODE_SAT) || (w_mode == MODE_ONESHOT);
  assign w_frozen = (w_mode == MODE_ONESHOT) && r_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = r_done;
    if (load) begin
      w_count_nxt = load_val;
      w_done_nxt  = 1'b0;
    end else if (w_step && !w_frozen) begin
      if (up) begin
        if (r_count >= limit) begin
          if (!w_sat) begin
            w_count_nxt = '0;
            w_tick_nxt  = 1'b1;
          end else if (r_count != limit) begin
            w_count_nxt = limit;
            w_tick_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + 1'b1;
          w_tick_nxt  = w_sat && ((r_count + 1'b1) == limit);
        end
      end else begin
        if (r_count == '0) begin
          if (!w_sat) begin
            w_count_nxt = limit;
            w_tick_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = r_count - 1'b1;
          w_tick_nxt  = w_sat && (r_count == WIDTH'(1));
        end
      end
      // Any boundary landing in one-shot mode finishes the shot.
      if (w_mode == MODE_ONESHOT && w_tick_nxt) begin
        w_done_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tick  <= w_tick_nxt;
      r_match <= (w_count_nxt == cmp_val);
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign match = r_match;
  assign done  = r_done;

endmodule
